// File: rtl/des_round_engine.sv
// des_round_engine: iterative DES datapath, one Feistel round per clock.
//   IP on accept, 16 rounds, FP folded into the last round edge.
// Ports:
//   clk, rst_n   - rising-edge clock, asynchronous active-low reset
//   start        - request, sampled only while idle
//   decrypt      - 0 encrypt / 1 decrypt, captured with start
//   din[64:1]    - input block (bit 64 = DES bit 1), captured with start
//   subkeys      - {k1..k16}, k1 at [768:721]; must stay stable during a run
//   busy         - high while rounds are in progress
//   dout_valid   - one-cycle pulse when dout updates
//   dout[64:1]   - result block, held until the next completion
module des_round_engine (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          decrypt,
    input  logic [64:1]   din,
    input  logic [768:1]  subkeys,
    output logic          busy,
    output logic          dout_valid,
    output logic [64:1]   dout
);
    typedef enum logic {IDLE, ROUND} state_t;

    localparam int IP_T [64] = '{
        58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
        62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
        57,49,41,33,25,17, 9,1, 59,51,43,35,27,19,11,3,
        61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{
        40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
        38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
        36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
        34,2,42,10,50,18,58,26, 33,1,41, 9,49,17,57,25};
    localparam int E_T [48] = '{
        32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
        16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32] = '{
        16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
        2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    // Each box is row-major: index = {b1,b6,b2..b5} of its 6-bit input.
    localparam logic [3:0] SBOX [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    // Table entry t names DES bit t, which lives at vector index (width+1-t).
    function automatic logic [64:1] ip_f(input logic [64:1] x);
        logic [64:1] y;
        for (int j = 1; j <= 64; j++) y[65-j] = x[65-IP_T[j-1]];
        return y;
    endfunction

    function automatic logic [64:1] fp_f(input logic [64:1] x);
        logic [64:1] y;
        for (int j = 1; j <= 64; j++) y[65-j] = x[65-FP_T[j-1]];
        return y;
    endfunction

    function automatic logic [32:1] feistel_f(input logic [32:1] r, input logic [48:1] k);
        logic [48:1] x;
        logic [32:1] s;
        logic [32:1] y;
        logic [5:0]  six;
        for (int j = 1; j <= 48; j++) x[49-j] = r[33-E_T[j-1]] ^ k[49-j];
        for (int b = 0; b < 8; b++) begin
            six = x[48-6*b -: 6];
            s[32-4*b -: 4] = SBOX[b][{six[5], six[0], six[4:1]}];
        end
        for (int j = 1; j <= 32; j++) y[33-j] = s[33-P_T[j-1]];
        return y;
    endfunction

    state_t      state_q, state_d;
    logic [32:1] l_q, l_d, r_q, r_d;
    logic [4:0]  ctr_q, ctr_d;
    logic        dec_q, dec_d;
    logic        busy_q, busy_d;
    logic        dout_valid_q, dout_valid_d;
    logic [64:1] dout_q, dout_d;

    logic [4:0]  kidx;
    logic [48:1] rk;
    logic [32:1] f_out;

    // Decryption walks the same schedule backwards: round r uses k(17-r).
    always_comb begin
        kidx = dec_q ? (5'd17 - ctr_q) : ctr_q;
        rk   = '0;
        for (int i = 1; i <= 16; i++)
            if (5'(i) == kidx) rk = subkeys[816-48*i -: 48];
        f_out = feistel_f(r_q, rk);
    end

    always_comb begin
        state_d      = state_q;
        l_d          = l_q;
        r_d          = r_q;
        ctr_d        = ctr_q;
        dec_d        = dec_q;
        busy_d       = busy_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                {l_d, r_d} = ip_f(din);
                ctr_d      = 5'd1;
                dec_d      = decrypt;
                busy_d     = 1'b1;
                state_d    = ROUND;
            end
            ROUND: begin
                l_d   = r_q;
                r_d   = l_q ^ f_out;
                ctr_d = ctr_q + 5'd1;
                if (ctr_q == 5'd16) begin
                    // Output is {R16,L16}: the final swap undoes the last L/R exchange.
                    dout_d       = fp_f({l_q ^ f_out, r_q});
                    dout_valid_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            l_q          <= '0;
            r_q          <= '0;
            ctr_q        <= '0;
            dec_q        <= 1'b0;
            busy_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
        end else begin
            state_q      <= state_d;
            l_q          <= l_d;
            r_q          <= r_d;
            ctr_q        <= ctr_d;
            dec_q        <= dec_d;
            busy_q       <= busy_d;
            dout_valid_q <= dout_valid_d;
            dout_q       <= dout_d;
        end
    end

    assign busy       = busy_q;
    assign dout_valid = dout_valid_q;
    assign dout       = dout_q;
endmodule
